// File: rtl/matmul_mac_ctrl_if.sv
// matmul_mac_ctrl_if: A/B RAM read ports, mac operand/result link, C RAM write port.
// master = sequencer side (drives addresses, operands, C writes); slave = RAMs and mac.
interface matmul_mac_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2
);
  localparam int ACC_W = 2*DATA_W + $clog2(K) + 1;
  localparam int AW_A  = (M*K > 1) ? $clog2(M*K) : 1;
  localparam int AW_B  = (K*N > 1) ? $clog2(K*N) : 1;
  localparam int AW_C  = (M*N > 1) ? $clog2(M*N) : 1;

  logic        [AW_A-1:0]   a_raddr;
  logic signed [DATA_W-1:0] a_rdata;
  logic        [AW_B-1:0]   b_raddr;
  logic signed [DATA_W-1:0] b_rdata;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic                     mac_acc_clear;
  logic signed [ACC_W-1:0]  mac_acc;
  logic                     mac_acc_valid;
  logic                     c_we;
  logic        [AW_C-1:0]   c_waddr;
  logic signed [ACC_W-1:0]  c_wdata;

  modport master (
    output a_raddr, b_raddr,
    output mac_a, mac_b, mac_acc_clear,
    output c_we, c_waddr, c_wdata,
    input  a_rdata, b_rdata,
    input  mac_acc, mac_acc_valid
  );

  modport slave (
    input  a_raddr, b_raddr,
    input  mac_a, mac_b, mac_acc_clear,
    input  c_we, c_waddr, c_wdata,
    output a_rdata, b_rdata,
    output mac_acc, mac_acc_valid
  );
endinterface

// File: rtl/matmul_mac_ctrl.sv
// matmul_mac_ctrl: sequences A/B reads into mac and writes each dot product to C.
// Ports: clk, rst (sync, high), start, busy, done, bus (RAM/mac/C master).
module matmul_mac_ctrl #(
  parameter int DATA_W = 16,
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  matmul_mac_ctrl_if.master bus
);
  localparam int AW_A = (M*K > 1) ? $clog2(M*K) : 1;
  localparam int AW_B = (K*N > 1) ? $clog2(K*N) : 1;
  localparam int AW_C = (M*N > 1) ? $clog2(M*N) : 1;
  localparam int IW   = (M > 1) ? $clog2(M) : 1;
  localparam int JW   = (N > 1) ? $clog2(N) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int WW   = $clog2(M*N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t st, nxt;

  logic [IW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [KW-1:0] k_q;
  logic [WW-1:0] wr_q;
  logic          issue;
  logic          last;
  logic          dv_q;
  logic          ft_q;
  logic          clr_q;
  logic          cap_q;
  logic          cap;
  logic          we_q;
  logic [AW_C-1:0] waddr_q;
  logic signed [$bits(bus.c_wdata)-1:0] wdata_q;

  assign last = (i_q == IW'(M-1)) &&
                (j_q == JW'(N-1)) &&
                (k_q == KW'(K-1));

  // A held result or post-reset garbage valid is ignored until the
  // next clear re-arms capture.
  assign cap = bus.mac_acc_valid && !cap_q;

  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt   = st;
    busy  = 1'b1;
    done  = 1'b0;
    issue = 1'b0;
    unique case (st)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nxt = S_ISSUE;
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (last) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_q == WW'(M*N)) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      wr_q    <= '0;
      dv_q    <= 1'b0;
      ft_q    <= 1'b0;
      clr_q   <= 1'b0;
      cap_q   <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      dv_q  <= issue;
      ft_q  <= issue && (k_q == '0);
      clr_q <= dv_q && ft_q;
      if (issue) begin
        if (k_q == KW'(K-1)) begin
          k_q <= '0;
          if (j_q == JW'(N-1)) begin
            j_q <= '0;
            i_q <= (i_q == IW'(M-1)) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
      if (st == S_IDLE && start) wr_q <= '0;
      we_q <= cap;
      if (cap) begin
        wdata_q <= bus.mac_acc;
        waddr_q <= AW_C'(wr_q);
        wr_q    <= wr_q + 1'b1;
      end
      // A clear in the capture cycle belongs to the next dot product.
      if (clr_q)    cap_q <= 1'b0;
      else if (cap) cap_q <= 1'b1;
    end
  end

  assign bus.a_raddr = AW_A'(int'(i_q) * K + int'(k_q));
  assign bus.b_raddr = AW_B'(int'(k_q) * N + int'(j_q));
  assign bus.mac_a   = dv_q ? bus.a_rdata : {DATA_W{1'b0}};
  assign bus.mac_b   = dv_q ? bus.b_rdata : {DATA_W{1'b0}};
  assign bus.mac_acc_clear = clr_q;
  assign bus.c_we    = we_q;
  assign bus.c_waddr = waddr_q;
  assign bus.c_wdata = wdata_q;
endmodule
